ip_iobus_ctrl: RTL and testbench

- Front-end sequencer between the raw MSX cartridge-slot I/O strobes and the internal one-clock peripheral bus used by the GPIO and other I/O IP blocks.
- Synchronises /IORQ, /RD and /WR and issues single-cycle bus_io_read / bus_io_write pulses with latched address and data.
- Collects the registered read responses of up to NUM_DEV peripherals and drives the slot data bus until the MSX ends the cycle.
- Inserts /WAIT while a read response is pending; a timeout covers unmapped ports.

---
 rtl/ip_iobus_ctrl.sv | 142 ++++++++++++++
 tb/tb_ip_iobus_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_iobus_ctrl.sv
// MSX cartridge-slot I/O front end: synchronises /IORQ, /RD and /WR, issues one-clock peripheral
// bus strobes, returns registered read data to the slot and holds /WAIT while a response is pending.
module ip_iobus_ctrl #(
   parameter int NUM_DEV = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic [15:0]            msx_a,
   input  logic [7:0]             msx_d_in,
   input  logic                   msx_n_iorq,
   input  logic                   msx_n_rd,
   input  logic                   msx_n_wr,
   output logic [7:0]             msx_d_out,
   output logic                   msx_d_oe,
   output logic                   msx_n_wait,
   output logic [15:0]            bus_address,
   output logic [7:0]             bus_write_data,
   output logic                   bus_io_read,
   output logic                   bus_io_write,
   input  logic [NUM_DEV-1:0]     dev_read_ready,
   input  logic [8*NUM_DEV-1:0]   dev_read_data,
   output logic                   bus_conflict
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_HOLD = 2'd2,
      WR_HOLD = 2'd3
   } state_t;

   state_t      state;
   logic        n_iorq_p0, n_iorq_p1;
   logic        n_rd_p0, n_rd_p1;
   logic        n_wr_p0, n_wr_p1;
   logic        rd_s, wr_s;
   logic [7:0]  tmo_cnt;
   logic [7:0]  rd_mux;
   logic        any_ready;
   logic        multi_ready;

   assign rd_s = ~n_iorq_p1 & ~n_rd_p1;
   assign wr_s = ~n_iorq_p1 & ~n_wr_p1;

   // Responders that are not ready contribute zero, so the OR is the selected data.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         rd_mux = rd_mux | (dev_read_data[8*i +: 8] & {8{dev_read_ready[i]}});
      end
   end

   assign any_ready   = |dev_read_ready;
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_ready = |(dev_read_ready & (dev_read_ready - NUM_DEV'(1)));

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state          <= IDLE;
         n_iorq_p0      <= 1'b1;
         n_iorq_p1      <= 1'b1;
         n_rd_p0        <= 1'b1;
         n_rd_p1        <= 1'b1;
         n_wr_p0        <= 1'b1;
         n_wr_p1        <= 1'b1;
         bus_address    <= '0;
         bus_write_data <= '0;
         bus_io_read    <= 1'b0;
         bus_io_write   <= 1'b0;
         msx_d_out      <= '0;
         msx_d_oe       <= 1'b0;
         msx_n_wait     <= 1'b1;
         bus_conflict   <= 1'b0;
         tmo_cnt        <= '0;
      end else begin
         // synchroniser stage p0 -> p1
         n_iorq_p0    <= msx_n_iorq;
         n_iorq_p1    <= n_iorq_p0;
         n_rd_p0      <= msx_n_rd;
         n_rd_p1      <= n_rd_p0;
         n_wr_p0      <= msx_n_wr;
         n_wr_p1      <= n_wr_p0;

         bus_io_read  <= 1'b0;
         bus_io_write <= 1'b0;
         bus_conflict <= 1'b0;

         case (state)
            IDLE: begin
               if (rd_s) begin
                  bus_address <= msx_a;
                  bus_io_read <= 1'b1;
                  msx_n_wait  <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= RD_WAIT;
               end else if (wr_s) begin
                  bus_address    <= msx_a;
                  bus_write_data <= msx_d_in;
                  bus_io_write   <= 1'b1;
                  state          <= WR_HOLD;
               end
            end

            RD_WAIT: begin
               tmo_cnt <= tmo_cnt + 8'd1;
               if (!rd_s) begin
                  msx_n_wait <= 1'b1;
                  msx_d_oe   <= 1'b0;
                  state      <= IDLE;
               end else if (any_ready) begin
                  msx_d_out    <= rd_mux;
                  msx_d_oe     <= 1'b1;
                  msx_n_wait   <= 1'b1;
                  bus_conflict <= multi_ready;
                  state        <= RD_HOLD;
               end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                  // Nobody decoded the port: release /WAIT and let the slot pull-ups read FFh.
                  msx_n_wait <= 1'b1;
                  state      <= RD_HOLD;
               end
            end

            RD_HOLD: begin
               if (!rd_s) begin
                  msx_d_oe <= 1'b0;
                  state    <= IDLE;
               end
            end

            WR_HOLD: begin
               if (!wr_s) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ip_iobus_ctrl.sv
// Self-checking bench for ip_iobus_ctrl: registered peripheral models plus a transaction-level
// reference model of the expected strobes, /WAIT length and slot read data.
module tb_ip_iobus_ctrl;
   localparam int NUM_DEV = 4;
   localparam int TIMEOUT = 15;

   logic                 clk = 1'b0;
   logic                 n_reset;
   logic [15:0]          msx_a;
   logic [7:0]           msx_d_in;
   logic                 msx_n_iorq, msx_n_rd, msx_n_wr;
   logic [7:0]           msx_d_out;
   logic                 msx_d_oe, msx_n_wait;
   logic [15:0]          bus_address;
   logic [7:0]           bus_write_data;
   logic                 bus_io_read, bus_io_write;
   logic [NUM_DEV-1:0]   dev_read_ready;
   logic [8*NUM_DEV-1:0] dev_read_data;
   logic                 bus_conflict;

   ip_iobus_ctrl #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .n_reset(n_reset), .msx_a(msx_a), .msx_d_in(msx_d_in),
      .msx_n_iorq(msx_n_iorq), .msx_n_rd(msx_n_rd), .msx_n_wr(msx_n_wr),
      .msx_d_out(msx_d_out), .msx_d_oe(msx_d_oe), .msx_n_wait(msx_n_wait),
      .bus_address(bus_address), .bus_write_data(bus_write_data),
      .bus_io_read(bus_io_read), .bus_io_write(bus_io_write),
      .dev_read_ready(dev_read_ready), .dev_read_data(dev_read_data),
      .bus_conflict(bus_conflict)
   );

   always #5 clk = ~clk;

   // Peripherals answer one clock after bus_io_read; device 0 is the GPIO (gpi = dev_val[0]).
   logic [7:0] dev_addr [NUM_DEV];
   logic [7:0] dev_val  [NUM_DEV];
   logic [7:0] gpo;

   always @(posedge clk) begin
      for (int i = 0; i < NUM_DEV; i++)
         dev_read_ready[i] <= bus_io_read && (bus_address[7:0] == dev_addr[i]);
      if (bus_io_write && bus_address[7:0] == dev_addr[0]) gpo <= bus_write_data;
   end

   always_comb begin
      dev_read_data = '0;
      for (int i = 0; i < NUM_DEV; i++) dev_read_data[8*i +: 8] = dev_val[i];
   end

   int n_vec = 0, n_err = 0;
   int m_rd, m_wr, m_wait, m_oe, m_conf, m_rd_e, m_wr_e, m_wait_e, m_oe_e;
   logic [7:0] m_data;
   logic [7:0] exp_gpo, exp_wd;

   function automatic int n_match(input logic [7:0] a);
      int n = 0;
      for (int i = 0; i < NUM_DEV; i++) if (dev_addr[i] == a) n++;
      return n;
   endfunction

   function automatic logic [7:0] or_data(input logic [7:0] a);
      logic [7:0] r = 8'h00;
      for (int i = 0; i < NUM_DEV; i++) if (dev_addr[i] == a) r = r | dev_val[i];
      return r;
   endfunction

   // Drive one MSX I/O cycle with the strobe sampled low for len edges and record what the DUT does.
   task automatic run_cycle(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [7:0] d, input int len);
      m_rd = 0; m_wr = 0; m_wait = 0; m_oe = 0; m_conf = 0;
      m_rd_e = -1; m_wr_e = -1; m_wait_e = -1; m_oe_e = -1; m_data = 8'h00;
      @(posedge clk); #1;
      msx_a = a; msx_d_in = d; msx_n_iorq = 1'b0; msx_n_rd = ~rd; msx_n_wr = ~wr;
      for (int e = 0; e < len + TIMEOUT + 8; e++) begin
         @(posedge clk); #1;
         if (bus_io_read)  begin m_rd++; if (m_rd_e < 0) m_rd_e = e; end
         if (bus_io_write) begin m_wr++; if (m_wr_e < 0) m_wr_e = e; end
         if (!msx_n_wait)  begin m_wait++; if (m_wait_e < 0) m_wait_e = e; end
         if (msx_d_oe)     begin m_oe++; if (m_oe_e < 0) begin m_oe_e = e; m_data = msx_d_out; end end
         if (bus_conflict) m_conf++;
         if (e == len - 1) begin msx_n_iorq = 1'b1; msx_n_rd = 1'b1; msx_n_wr = 1'b1; end
      end
   endtask

   task automatic test_reset;
      n_reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({bus_io_read, bus_io_write, msx_d_oe, msx_n_wait, bus_conflict} !== 5'b00010) begin
         n_err++; $display("FAIL reset_ctrl: got %b expected 00010", {bus_io_read, bus_io_write, msx_d_oe, msx_n_wait, bus_conflict});
      end
      n_vec++;
      if ({bus_address, bus_write_data, msx_d_out} !== 32'h0) begin
         n_err++; $display("FAIL reset_data: got %h expected 00000000", {bus_address, bus_write_data, msx_d_out});
      end
      n_reset = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_gpio_write;
      run_cycle(1'b0, 1'b1, 16'h0001, 8'h5A, 6);
      n_vec++;
      if (m_wr !== 1 || m_wr_e !== 2 || m_rd !== 0) begin
         n_err++; $display("FAIL gpio_write_pulse: got wr=%0d at %0d rd=%0d expected wr=1 at 2 rd=0", m_wr, m_wr_e, m_rd);
      end
      n_vec++;
      if (bus_address !== 16'h0001 || bus_write_data !== 8'h5A) begin
         n_err++; $display("FAIL gpio_write_latch: got %h/%h expected 0001/5a", bus_address, bus_write_data);
      end
      n_vec++;
      if (gpo !== 8'h5A || m_wait !== 0 || m_oe !== 0) begin
         n_err++; $display("FAIL gpio_write_gpo: got gpo=%h wait=%0d oe=%0d expected 5a 0 0", gpo, m_wait, m_oe);
      end
      exp_gpo = 8'h5A; exp_wd = 8'h5A;
   endtask

   task automatic test_gpio_read;
      dev_val[0] = 8'hC3;
      run_cycle(1'b1, 1'b0, 16'h0001, 8'h00, 6);
      n_vec++;
      if (m_rd !== 1 || m_rd_e !== 2 || m_wr !== 0) begin
         n_err++; $display("FAIL gpio_read_pulse: got rd=%0d at %0d wr=%0d expected 1 at 2, 0", m_rd, m_rd_e, m_wr);
      end
      n_vec++;
      if (m_wait_e !== 2 || m_wait !== 2) begin
         n_err++; $display("FAIL gpio_read_wait: got start %0d len %0d expected 2 2", m_wait_e, m_wait);
      end
      n_vec++;
      if (m_oe_e !== 4 || m_oe !== 4 || m_data !== 8'hC3) begin
         n_err++; $display("FAIL gpio_read_data: got oe at %0d for %0d data %h expected 4 4 c3", m_oe_e, m_oe, m_data);
      end
   endtask

   task automatic test_unmapped;
      run_cycle(1'b1, 1'b0, 16'h007F, 8'h00, TIMEOUT + 4);
      n_vec++;
      if (m_wait !== TIMEOUT || m_wait_e !== 2) begin
         n_err++; $display("FAIL unmapped_wait: got %0d from %0d expected %0d from 2", m_wait, m_wait_e, TIMEOUT);
      end
      n_vec++;
      if (m_oe !== 0 || m_conf !== 0 || m_rd !== 1) begin
         n_err++; $display("FAIL unmapped_oe: got oe=%0d conf=%0d rd=%0d expected 0 0 1", m_oe, m_conf, m_rd);
      end
      n_vec++;
      if (msx_n_wait !== 1'b1 || msx_d_oe !== 1'b0) begin
         n_err++; $display("FAIL unmapped_end: got wait=%b oe=%b expected 1 0", msx_n_wait, msx_d_oe);
      end
   endtask

   task automatic test_conflict;
      logic [7:0] save_addr;
      save_addr = dev_addr[2];
      dev_val[0] = 8'h0F; dev_val[2] = 8'h30; dev_addr[2] = 8'h01;
      run_cycle(1'b1, 1'b0, 16'h0001, 8'h00, 7);
      n_vec++;
      if (m_data !== 8'h3F || m_oe !== 5) begin
         n_err++; $display("FAIL conflict_data: got %h for %0d expected 3f for 5", m_data, m_oe);
      end
      n_vec++;
      if (m_conf !== 1) begin
         n_err++; $display("FAIL conflict_pulse: got %0d expected 1", m_conf);
      end
      dev_addr[2] = save_addr;
   endtask

   task automatic test_abort_overlap;
      run_cycle(1'b1, 1'b0, 16'h00E5, 8'h00, 2);
      n_vec++;
      if (m_rd !== 1 || m_wait !== 2 || m_oe !== 0) begin
         n_err++; $display("FAIL abort: got rd=%0d wait=%0d oe=%0d expected 1 2 0", m_rd, m_wait, m_oe);
      end
      dev_val[0] = 8'h66;
      run_cycle(1'b1, 1'b1, 16'h0001, 8'hAA, 6);
      n_vec++;
      if (m_rd !== 1 || m_wr !== 0) begin
         n_err++; $display("FAIL overlap_pulses: got rd=%0d wr=%0d expected 1 0", m_rd, m_wr);
      end
      n_vec++;
      if (m_data !== 8'h66 || gpo !== exp_gpo || bus_write_data !== exp_wd) begin
         n_err++; $display("FAIL overlap_data: got %h gpo=%h wd=%h expected 66 %h %h", m_data, gpo, bus_write_data, exp_gpo, exp_wd);
      end
   endtask

   task automatic test_reset_hold;
      int rd_cnt, rd_e2, oe_post;
      rd_cnt = 0; rd_e2 = -1; oe_post = 0;
      dev_val[0] = 8'h96;
      @(posedge clk); #1;
      msx_a = 16'h0001; msx_n_iorq = 1'b0; msx_n_rd = 1'b0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         if (bus_io_read) begin rd_cnt++; if (e > 7) rd_e2 = e; end
         if (msx_d_oe && e > 7) oe_post++;
         if (e == 6) begin
            n_vec++;
            if (msx_d_oe !== 1'b1 || msx_d_out !== 8'h96) begin
               n_err++; $display("FAIL hold_before_reset: got oe=%b d=%h expected 1 96", msx_d_oe, msx_d_out);
            end
            n_reset = 1'b0;
         end
         if (e == 7) begin
            n_vec++;
            if (msx_d_oe !== 1'b0 || msx_n_wait !== 1'b1 || bus_write_data !== 8'h00) begin
               n_err++; $display("FAIL reset_in_hold: got oe=%b wait=%b wd=%h expected 0 1 00", msx_d_oe, msx_n_wait, bus_write_data);
            end
            n_reset = 1'b1;
         end
         if (e == 20) begin msx_n_iorq = 1'b1; msx_n_rd = 1'b1; end
      end
      n_vec++;
      if (rd_cnt !== 2 || rd_e2 !== 10) begin
         n_err++; $display("FAIL reset_new_cycle: got %0d pulses, second at %0d expected 2, 10", rd_cnt, rd_e2);
      end
      n_vec++;
      if (oe_post !== 11 || bus_address !== 16'h0001) begin
         n_err++; $display("FAIL reset_new_read: got oe=%0d addr=%h expected 11 0001", oe_post, bus_address);
      end
      exp_wd = 8'h00;
   endtask

   task automatic test_random;
      for (int t = 0; t < 30; t++) begin
         int kind, len, nm, e_rd, e_wr, e_wait, e_oe, e_conf;
         logic [15:0] a;
         logic [7:0] d, e_data;
         for (int i = 0; i < NUM_DEV; i++) dev_val[i] = 8'($urandom);
         kind = $urandom_range(0, 3);
         d = 8'($urandom);
         if (kind == 1) begin
            a = 16'($urandom);
            while (n_match(a[7:0]) != 0) a = 16'($urandom);
            len = $urandom_range(1, TIMEOUT + 4);
         end else begin
            a = {8'($urandom), dev_addr[$urandom_range(0, NUM_DEV - 1)]};
            len = (kind == 2) ? $urandom_range(1, 8) : $urandom_range(3, 10);
         end
         run_cycle(kind != 2, kind >= 2, a, d, len);
         e_data = 8'h00; e_conf = 0;
         if (kind == 2) begin
            e_rd = 0; e_wr = 1; e_wait = 0; e_oe = 0;
            exp_wd = d;
            if (a[7:0] == dev_addr[0]) exp_gpo = d;
         end else begin
            nm = n_match(a[7:0]);
            e_rd = 1; e_wr = 0;
            if (nm > 0) begin
               e_wait = 2; e_oe = len - 2; e_data = or_data(a[7:0]); e_conf = (nm > 1) ? 1 : 0;
            end else begin
               e_wait = (len < TIMEOUT) ? len : TIMEOUT; e_oe = 0;
            end
         end
         n_vec++;
         if (m_rd !== e_rd || m_wr !== e_wr || m_wait !== e_wait || m_oe !== e_oe || m_conf !== e_conf) begin
            n_err++;
            $display("FAIL rand_seq[%0d] kind %0d len %0d: got rd=%0d wr=%0d wait=%0d oe=%0d conf=%0d expected %0d %0d %0d %0d %0d",
                     t, kind, len, m_rd, m_wr, m_wait, m_oe, m_conf, e_rd, e_wr, e_wait, e_oe, e_conf);
         end
         n_vec++;
         if (bus_address !== a || bus_write_data !== exp_wd || gpo !== exp_gpo || (e_oe > 0 && m_data !== e_data)) begin
            n_err++;
            $display("FAIL rand_data[%0d]: got addr=%h wd=%h gpo=%h d=%h expected %h %h %h %h",
                     t, bus_address, bus_write_data, gpo, m_data, a, exp_wd, exp_gpo, e_data);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      msx_a = 16'h0000; msx_d_in = 8'h00;
      msx_n_iorq = 1'b1; msx_n_rd = 1'b1; msx_n_wr = 1'b1;
      dev_addr[0] = 8'h01; dev_addr[1] = 8'h10; dev_addr[2] = 8'h20; dev_addr[3] = 8'h30;
      for (int i = 0; i < NUM_DEV; i++) dev_val[i] = 8'h00;
      exp_gpo = 8'h00; exp_wd = 8'h00;
      test_reset();
      test_gpio_write();
      test_gpio_read();
      test_unmapped();
      test_conflict();
      test_abort_overlap();
      test_reset_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
